ic_bvsge_bvudiv_checker: RTL

Sequential witness checker for the bvsge/bvudiv invertibility condition. It accepts a candidate witness `x` with operands `s` and `t`, computes `q = x udiv s` using SMT-LIB semantics, and reports whether `signed(q) >= signed(t)`. The block is the consumer end of the Skolem-function flow: a generator proposes witness bits, and this block confirms them in hardware for bring-up and regression.

---
 rtl/ic_bvsge_bvudiv_checker_if.sv | 26 ++
 rtl/ic_bvsge_bvudiv_checker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ic_bvsge_bvudiv_checker_if.sv
// Request/result handshake bundle for the bvsge/bvudiv witness checker.
// The master side proposes witnesses and consumes results; the checker is the slave.
interface ic_bvsge_bvudiv_checker_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_s;
  logic [W-1:0] in_t;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_q;
  logic         out_holds;
  logic         out_div0;

  modport master (
    output in_valid, in_x, in_s, in_t, out_ready,
    input  in_ready, out_valid, out_q, out_holds, out_div0
  );

  modport slave (
    input  in_valid, in_x, in_s, in_t, out_ready,
    output in_ready, out_valid, out_q, out_holds, out_div0
  );
endinterface

// File: rtl/ic_bvsge_bvudiv_checker.sv
// Witness checker: q = x udiv s (SMT-LIB, div-by-zero gives all ones) by
// restoring division one bit per cycle, then reports signed(q) >= signed(t).
module ic_bvsge_bvudiv_checker #(
  parameter int W = 4
) (
  input logic                       clk,
  input logic                       rst,
  ic_bvsge_bvudiv_checker_if.slave  bus
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    CMP  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [W-1:0]        x_l;
  logic [W-1:0]        s_l;
  logic signed [W-1:0] t_l;
  logic [W:0]          r;
  logic [W-1:0]        q;
  logic [KW-1:0]       k;

  logic                in_ready_r;
  logic                out_valid_r;
  logic [W-1:0]        out_q_r;
  logic                out_holds_r;
  logic                out_div0_r;

  logic                accept;
  logic [W:0]          r_sh;
  logic                step_ge;
  logic [W:0]          r_nxt;

  // Two's-complement >= built as MSB-flip followed by an unsigned compare.
  function automatic logic signed_ge(input logic signed [W-1:0] a,
                                     input logic signed [W-1:0] b);
    logic [W-1:0] ua;
    logic [W-1:0] ub;
    ua = {~a[W-1], a[W-2:0]};
    ub = {~b[W-1], b[W-2:0]};
    return (ua >= ub);
  endfunction

  // Shift in the next dividend bit; the top remainder bit falls off, which
  // only matters for s == 0 where every trial subtract succeeds anyway.
  function automatic logic [W:0] shift_in(input logic [W:0] rem, input logic xb);
    return (W+1)'({rem, xb});
  endfunction

  // ---- control: state register and handshake flags
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = DIV;
        end
      end
      DIV: begin
        if (k == '0) state_nxt = CMP;
      end
      CMP: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_r  <= (state_nxt == IDLE);
      out_valid_r <= (state_nxt == HOLD);
    end
  end

  // ---- division step: trial subtract of the shifted remainder
  always_comb begin
    r_sh    = shift_in(r, x_l[k]);
    step_ge = (r_sh >= {1'b0, s_l});
    r_nxt   = step_ge ? (r_sh - {1'b0, s_l}) : r_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_l <= '0;
      s_l <= '0;
      t_l <= '0;
      r   <= '0;
      q   <= '0;
      k   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_l <= bus.in_x;
            s_l <= bus.in_s;
            t_l <= bus.in_t;
            r   <= '0;
            q   <= '0;
            k   <= KW'(W-1);
          end
        end
        DIV: begin
          r    <= r_nxt;
          q[k] <= step_ge;
          if (k != '0) k <= k - KW'(1);
        end
        default: ;
      endcase
    end
  end

  // ---- result registers: loaded once in CMP, frozen through HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q_r     <= '0;
      out_holds_r <= 1'b0;
      out_div0_r  <= 1'b0;
    end else if (state == CMP) begin
      out_q_r     <= q;
      out_holds_r <= signed_ge($signed(q), t_l);
      out_div0_r  <= (s_l == '0);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_q     = out_q_r;
  assign bus.out_holds = out_holds_r;
  assign bus.out_div0  = out_div0_r;

  a_ready_valid_excl: assert property (@(posedge clk) disable iff (rst)
    !(in_ready_r && out_valid_r));

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid_r && !bus.out_ready) |=>
      (out_valid_r && $stable(out_q_r) && $stable(out_holds_r) && $stable(out_div0_r)));

endmodule
